control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit driving the Datapath_P2 control inputs.
//  Replaces the bench-driven T0..Tn stimulus with an on-chip FSM:
//  fetch T0-T2, decode IR, then per-opcode execute steps T3-T7.
//  Sits beside Datapath_P2; IR, CON_FF in, every enable/strobe out.
// PARAMETERS
//  OPW  5  opcode width, IR[31:27]; field slices fixed at ra=IR[26:23], rb=[22:19], rc=[18:15]
// PORTS
//  Clock      in   1  single clock; all state changes on its rising edge
//  Clear      in   1  asynchronous, active-low reset
//  IR         in  32  instruction register contents from datapath
//  CON_FF     in   1  branch condition flip-flop
//  Stop       in   1  halt request, honoured at instruction boundary
//  PCout,Zhighout,Zlowout,MDRout,HIout,LOout,InPortout,Cout,BAout,Rout  out 1  bus drivers
//  MARin,Zin,PCin,MDRin,IRin,Yin,OutPortin,CONin,Rin                    out 1  reg loads
//  Gra,Grb,Grc out 1  register-field select; IncPC,Read,Write out 1
//  ALUop      out  4  ALU function code (ALU_* constants)
//  Run        out  1  1 while executing, 0 in reset or HALT
// BEHAVIOUR
//  - Moore: outputs decoded from state+IR only (sole exception: PCin in BR T6 gated by CON_FF).
//  - Clear low: state=RST immediately; all outputs 0, ALUop=ALU_NOP, Run=0.
//    First edge after release: RST->T0, Run=1.
//  - Fetch: T0 PCout MARin IncPC Zin | T1 Zlowout PCin Read MDRin | T2 MDRout IRin.
//  - IR loads at end of T2; T3+ decode IR directly (stable until next T2).
//  - Execute (only listed signals high; final step -> T0):
//    ADD/SUB/AND/OR: T3 Grb Rout Yin | T4 Grc Rout Zin ALUop=op | T5 Zlowout Gra Rin
//    ADDI: T3 Grb Rout Yin | T4 Cout Zin ALUop=ADD | T5 Zlowout Gra Rin
//    LDI: T3 Grb BAout Yin | T4 Cout Zin ALU_ADD | T5 Zlowout Gra Rin
//    LD: LDI T3-T4 | T5 Zlowout MARin | T6 Read MDRin | T7 MDRout Gra Rin
//    ST: LDI T3-T4 | T5 Zlowout MARin | T6 Gra Rout MDRin | T7 Write
//    BR: T3 Gra Rout CONin | T4 PCout Yin | T5 Cout Zin ALU_ADD | T6 Zlowout, PCin=CON_FF
//    JR: T3 Gra Rout PCin.  IN: T3 InPortout Gra Rin.  OUT: T3 Gra Rout OutPortin
//    MFHI: T3 HIout Gra Rin.  MFLO: T3 LOout Gra Rin.  (never Rout with HIout/LOout)
//    NOP and undefined opcodes: T3 all 0.
//    HALT: T3 -> HALT state; HALT holds all outputs 0, Run=0, exits only via Clear.
//  - Stop sampled on edge leaving an instruction's final step: 1 -> HALT, else T0.
//    Stop during fetch/mid-execute is ignored until that boundary.
//  - Exactly one bus driver high per step; Read and Write never both high.
//  - Clear mid-instruction abandons it; next fetch starts at T0.
// STRUCTURE
//  - control_pkg: OP_* opcodes (LD=00000 LDI=00001 ST=00010 ADD=00011 SUB=00100
//    AND=00101 OR=00110 ADDI=01100 BR=10011 JR=10100 IN=10110 OUT=10111
//    MFHI=11000 MFLO=11001 NOP=11010 HALT=11011), ALU_* codes, state encodings.
//  - Sub-module control_decode: combinational (state, IR[31:27], CON_FF) -> control word.
//    Top keeps state register, next-state logic, Stop/HALT handling.
// TESTING
//  1 Clear low in ADD T4 -> all outputs 0 same cycle, Run=0; release -> T0: PCout MARin IncPC Zin=1.
//  2 IR=32'hC1000000 (mfhi R2) -> T3 HIout Gra Rin=1, Rout=0; T0 at cycle 5; 4-cycle instr.
//  3 IR=32'h18918000 (add R1,R2,R3) -> T4 Grc Rout Zin ALUop=ALU_ADD; T5 Zlowout Gra Rin; 6 cycles.
//  4 ld R1,0x55(R0) IR=32'h00800055 -> T3 BAout Grb Yin; T6 Read MDRin; T7 MDRout Gra Rin; 8 cycles.
//  5 BR, CON_FF=0 then 1 -> T6 Zlowout both; PCin 0 then 1.
//  6 Stop=1 during ST T5 -> Write at T7, then HALT, Run=0, no T0; IR=32'hD8000000 halts identically.

Source files
------------

// File: rtl/control_pkg.sv
// Shared opcodes, ALU function codes, sequencer states and the control word
// exchanged between the state machine and its output decoder.
package control_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_IN   = 5'b10110;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;

    // T3..T7 must stay consecutive: execute steps advance by increment.
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out;
        logic       inport_out, c_out, ba_out, r_out;
        logic       mar_in, z_in, pc_in, mdr_in, ir_in, y_in, outport_in, con_in, r_in;
        logic       gra, grb, grc, inc_pc, read, write;
        logic [3:0] alu_op;
        logic       run;
    } ctrl_t;

    function automatic logic [3:0] alu_for_op(input logic [OPW-1:0] op);
        unique case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    // True when the given state is the final execute step of opcode op.
    function automatic logic is_last_step(input state_t s, input logic [OPW-1:0] op);
        unique case (s)
            S_T3:    return !(op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                                         OP_LDI, OP_LD, OP_ST, OP_BR});
            S_T5:    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI};
            S_T6:    return op == OP_BR;
            S_T7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational decode of sequencer state and opcode into the datapath control word.
module control_decode
    import control_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           con_ff,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_NOP;
        ctrl.run    = !(state inside {S_RST, S_HALT});
        unique case (state)
            S_T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1; end
            S_T1: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
            S_T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
            S_T3: begin
                unique case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                        begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                    OP_LD, OP_LDI, OP_ST:
                        begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                    OP_BR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
                    OP_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    OP_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OP_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
                    OP_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OP_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                        ctrl.alu_op = alu_for_op(opcode);
                    end
                    OP_ADDI, OP_LDI, OP_LD, OP_ST:
                        begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALU_ADD; end
                    OP_BR:   begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI:
                        begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OP_LD, OP_ST: begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
                    OP_BR:   begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                unique case (opcode)
                    OP_LD:   begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                    OP_ST:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
                    // The only output that depends on a live input rather than state.
                    OP_BR:   begin ctrl.zlow_out = 1'b1; ctrl.pc_in = con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                unique case (opcode)
                    OP_LD:   begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OP_ST:   ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/decode/execute state machine with Stop/HALT handling.
module control_sequencer
    import control_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
    output logic        InPortout, Cout, BAout, Rout,
    output logic        MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONin, Rin,
    output logic        Gra, Grb, Grc, IncPC, Read, Write,
    output logic [3:0]  ALUop,
    output logic        Run
);

    state_t         state_reg, state_next;
    ctrl_t          ctrl;
    logic [OPW-1:0] opcode;
    logic           unused_ir_fields;

    assign opcode           = IR[31:27];
    assign unused_ir_fields = ^IR[26:0];

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state_reg <= S_RST;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_RST:  state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_HALT: state_next = S_HALT;
            default: begin
                if (state_reg == S_T3 && opcode == OP_HALT)
                    state_next = S_HALT;
                else if (is_last_step(state_reg, opcode))
                    state_next = Stop ? S_HALT : S_T0;
                else
                    state_next = state_t'(state_reg + 4'd1);
            end
        endcase
    end

    control_decode u_decode (
        .state  (state_reg),
        .opcode (opcode),
        .con_ff (CON_FF),
        .ctrl   (ctrl)
    );

    assign PCout     = ctrl.pc_out;
    assign Zhighout  = ctrl.zhigh_out;
    assign Zlowout   = ctrl.zlow_out;
    assign MDRout    = ctrl.mdr_out;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign InPortout = ctrl.inport_out;
    assign Cout      = ctrl.c_out;
    assign BAout     = ctrl.ba_out;
    assign Rout      = ctrl.r_out;
    assign MARin     = ctrl.mar_in;
    assign Zin       = ctrl.z_in;
    assign PCin      = ctrl.pc_in;
    assign MDRin     = ctrl.mdr_in;
    assign IRin      = ctrl.ir_in;
    assign Yin       = ctrl.y_in;
    assign OutPortin = ctrl.outport_in;
    assign CONin     = ctrl.con_in;
    assign Rin       = ctrl.r_in;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign IncPC     = ctrl.inc_pc;
    assign Read      = ctrl.read;
    assign Write     = ctrl.write;
    assign ALUop     = ctrl.alu_op;
    assign Run       = ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised scoreboard bench: per-instruction step tables predict every cycle's control word.
module tb_control_sequencer;
    import control_pkg::*;

    logic        Clock = 1'b0;
    logic        Clear, CON_FF, Stop;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONin, Rin;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run;
    logic [3:0] ALUop;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .OutPortin(OutPortin), .CONin(CONin), .Rin(Rin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write), .ALUop(ALUop), .Run(Run)
    );

    always #5 Clock = ~Clock;

    localparam logic [24:0] PCOUT = 25'd1 << 24, ZHIGH = 25'd1 << 23, ZLOW = 25'd1 << 22,
        MDROUT = 25'd1 << 21, HIOUT = 25'd1 << 20, LOOUT = 25'd1 << 19, INPORT = 25'd1 << 18,
        COUT = 25'd1 << 17, BAOUT = 25'd1 << 16, ROUT = 25'd1 << 15, MARIN = 25'd1 << 14,
        ZIN = 25'd1 << 13, PCIN = 25'd1 << 12, MDRIN = 25'd1 << 11, IRIN = 25'd1 << 10,
        YIN = 25'd1 << 9, OUTPORT = 25'd1 << 8, CONIN = 25'd1 << 7, RIN = 25'd1 << 6,
        GRA = 25'd1 << 5, GRB = 25'd1 << 4, GRC = 25'd1 << 3, INCPC = 25'd1 << 2,
        READ = 25'd1 << 1, WRITE = 25'd1;
    localparam logic [29:0] ZW = '0;   // reset/halt: everything low, ALU_NOP, Run=0

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        stop;
        int          clr;
    } dir_t;

    logic [29:0] exp_q[$];
    logic [29:0] steps[$];
    dir_t        dq[$];
    int          n_checks = 0, n_fail = 0;
    int          idx, rst_cnt, halt_cnt, clr_step;
    bit          in_rst, halted, halt_op, directed, d_stop, stop_q;

    wire [29:0] got = {Run, ALUop, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout,
                       Cout, BAout, Rout, MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONin,
                       Rin, Gra, Grb, Grc, IncPC, Read, Write};

    function automatic logic [29:0] w(input logic [24:0] m, input logic [3:0] a);
        return {1'b1, a, m};
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    // Full step list of one instruction: three fetch steps then the execute recipe.
    task automatic build(input logic [4:0] op, input logic con);
        steps.delete();
        steps.push_back(w(PCOUT | MARIN | INCPC | ZIN, ALU_NOP));
        steps.push_back(w(ZLOW | PCIN | READ | MDRIN, ALU_NOP));
        steps.push_back(w(MDROUT | IRIN, ALU_NOP));
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                steps.push_back(w(GRB | ROUT | YIN, ALU_NOP));
                steps.push_back(w(GRC | ROUT | ZIN, alu_of(op)));
                steps.push_back(w(ZLOW | GRA | RIN, ALU_NOP));
            end
            OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
                steps.push_back(w((op == OP_ADDI ? ROUT : BAOUT) | GRB | YIN, ALU_NOP));
                steps.push_back(w(COUT | ZIN, ALU_ADD));
                if (op == OP_LD || op == OP_ST) begin
                    steps.push_back(w(ZLOW | MARIN, ALU_NOP));
                    steps.push_back(w(op == OP_LD ? (READ | MDRIN) : (GRA | ROUT | MDRIN), ALU_NOP));
                    steps.push_back(w(op == OP_LD ? (MDROUT | GRA | RIN) : WRITE, ALU_NOP));
                end else begin
                    steps.push_back(w(ZLOW | GRA | RIN, ALU_NOP));
                end
            end
            OP_BR: begin
                steps.push_back(w(GRA | ROUT | CONIN, ALU_NOP));
                steps.push_back(w(PCOUT | YIN, ALU_NOP));
                steps.push_back(w(COUT | ZIN, ALU_ADD));
                steps.push_back(w(ZLOW | (con ? PCIN : 25'd0), ALU_NOP));
            end
            OP_JR:   steps.push_back(w(GRA | ROUT | PCIN, ALU_NOP));
            OP_IN:   steps.push_back(w(INPORT | GRA | RIN, ALU_NOP));
            OP_OUT:  steps.push_back(w(GRA | ROUT | OUTPORT, ALU_NOP));
            OP_MFHI: steps.push_back(w(HIOUT | GRA | RIN, ALU_NOP));
            OP_MFLO: steps.push_back(w(LOOUT | GRA | RIN, ALU_NOP));
            default: steps.push_back(w(25'd0, ALU_NOP));
        endcase
    endtask

    function automatic logic [4:0] pick_op();
        logic [4:0] pool [16] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                                  OP_BR, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT};
        int k = $urandom_range(0, 19);
        if (k < 16) return pool[k];
        return 5'($urandom);
    endfunction

    task automatic new_instr();
        dir_t d;
        if (dq.size() > 0) begin
            d = dq.pop_front();
            directed = 1'b1;
        end else begin
            d.ir = {pick_op(), 27'($urandom)};
            d.con = 1'($urandom_range(0, 1));
            d.stop = 1'b0;
            d.clr = -1;
            directed = 1'b0;
        end
        IR = d.ir;
        CON_FF = d.con;
        d_stop = d.stop;
        clr_step = d.clr;
        halt_op = (d.ir[31:27] == OP_HALT);
        build(d.ir[31:27], d.con);
        idx = 0;
        $display("instr ir=%h con=%0d stop=%0d clr_step=%0d", d.ir, d.con, d.stop, d.clr);
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            logic [29:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL ctrl_word t=%0t got=%h exp=%h", $time, got, e);
            end
        end
    end

    initial begin
        Clear = 1'b0; IR = '0; CON_FF = 1'b0; Stop = 1'b0; stop_q = 1'b0;
        in_rst = 1'b1; rst_cnt = 2; halted = 1'b0; halt_cnt = 0; clr_step = -1;
        idx = 0; halt_op = 1'b0; directed = 1'b0; d_stop = 1'b0;
        dq.push_back('{32'h18918000, 1'b0, 1'b0, 4});   // add, cleared in T4
        dq.push_back('{32'hC1000000, 1'b0, 1'b0, -1});  // mfhi R2
        dq.push_back('{32'h18918000, 1'b0, 1'b0, -1});  // add R1,R2,R3
        dq.push_back('{32'h00800055, 1'b0, 1'b0, -1});  // ld R1,0x55(R0)
        dq.push_back('{32'h98800010, 1'b0, 1'b0, -1});  // br, condition false
        dq.push_back('{32'h98800010, 1'b1, 1'b0, -1});  // br, condition true
        dq.push_back('{32'h10800055, 1'b0, 1'b1, -1});  // st with Stop held high
        dq.push_back('{32'hD8000000, 1'b0, 1'b0, -1});  // halt

        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(posedge Clock);
            #1;
            if (!Clear) begin
                if (rst_cnt > 1) rst_cnt--;
                else Clear = 1'b1;
            end else if (in_rst) begin
                in_rst = 1'b0;
                new_instr();
            end else if (halted) begin
                halt_cnt++;
            end else if (idx == steps.size() - 1) begin
                if (halt_op || stop_q) begin
                    halted = 1'b1;
                    halt_cnt = 0;
                end else begin
                    new_instr();
                end
            end else begin
                idx++;
            end
            if (Clear && !in_rst) begin
                if ((halted && halt_cnt >= 3) || (!halted && idx == clr_step) ||
                    (!halted && !directed && $urandom_range(0, 79) == 0)) begin
                    Clear = 1'b0;
                    rst_cnt = 1 + $urandom_range(0, 1);
                    in_rst = 1'b1;
                    halted = 1'b0;
                    clr_step = -1;
                end
            end
            exp_q.push_back((in_rst || halted) ? ZW : steps[idx]);
            stop_q = directed ? d_stop : ($urandom_range(0, 29) == 0);
            Stop = stop_q;
        end

        repeat (2) @(negedge Clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
